// File: rtl/apb_timer.sv
// APB timer: prescaled down-counter with one-shot/periodic modes, sticky timeout
// flag, maskable level interrupt, programmable wait states and error response.
module apb_timer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  IRQ
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] WS        = WAIT_STATES[1:0];

    logic [1:0]           state_q, state_d, cur_st;
    logic [1:0]           wait_q, wait_d;
    logic                 en_q, en_d, per_q, per_d, ie_q, ie_d;
    logic [7:0]           presc_q, presc_d, pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0] load_q, load_d, value_q, value_d;
    logic                 tif_q, tif_d, irq_q;
    logic                 commit, err_c, wr_ok, ctrl_wr, load_wr, stat_wr;
    logic                 tick, tick_eff;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic                 unused_ok;

    assign unused_ok = ^{PADDR[ADDR_WIDTH-1:4], PWDATA};

    // Bus phase of the current cycle: a setup is recognised from the inputs, an
    // access only counts when it follows a setup or an unfinished access.
    always_comb begin
        cur_st = ST_IDLE;
        if (PSEL && !PENABLE) begin
            cur_st = ST_SETUP;
        end else if (PSEL && PENABLE && (state_q == ST_SETUP || state_q == ST_ACCESS)) begin
            cur_st = ST_ACCESS;
        end
    end

    always_comb begin
        case (cur_st)
            ST_ACCESS: PREADY = (wait_q == WS);
            ST_SETUP:  PREADY = 1'b0;
            default:   PREADY = (WAIT_STATES == 0);
        endcase
    end

    assign commit  = (cur_st == ST_ACCESS) && PREADY;
    assign state_d = commit ? ST_IDLE : cur_st;
    assign wait_d  = (cur_st == ST_ACCESS && !PREADY) ? wait_q + 2'd1 : 2'd0;

    assign err_c   = (PADDR[1:0] != 2'b00) || (PWRITE && PADDR[3:2] == 2'b10);
    assign PSLVERR = commit && err_c;
    assign wr_ok   = commit && PWRITE && !err_c;
    assign ctrl_wr = wr_ok && (PADDR[3:2] == 2'b00);
    assign load_wr = wr_ok && (PADDR[3:2] == 2'b01);
    assign stat_wr = wr_ok && (PADDR[3:2] == 2'b11);

    always_comb begin
        rdata_c = '0;
        case (PADDR[3:2])
            2'b00:   rdata_c[15:0] = {presc_q, 5'b0, ie_q, per_q, en_q};
            2'b01:   rdata_c[CNT_WIDTH-1:0] = load_q;
            2'b10:   rdata_c[CNT_WIDTH-1:0] = value_q;
            default: rdata_c[0] = tif_q;
        endcase
    end

    assign PRDATA = (PSEL && PENABLE && !err_c) ? rdata_c : '0;

    // A LOAD write in the same cycle as a tick wins and discards the tick.
    assign tick     = en_q && (pcnt_q >= presc_q);
    assign tick_eff = tick && !load_wr;

    always_comb begin
        en_d    = en_q;
        per_d   = per_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        load_d  = load_q;
        value_d = value_q;
        tif_d   = tif_q;
        pcnt_d  = pcnt_q;
        if (en_q) begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end
        if (stat_wr && PWDATA[0]) begin
            tif_d = 1'b0;
        end
        if (tick_eff) begin
            if (value_q != '0) begin
                value_d = value_q - CNT_WIDTH'(1);
            end else begin
                tif_d = 1'b1;
                if (per_q) begin
                    value_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
        if (ctrl_wr) begin
            en_d    = PWDATA[0];
            per_d   = PWDATA[1];
            ie_d    = PWDATA[2];
            presc_d = PWDATA[15:8];
            if (!en_q && PWDATA[0]) begin
                pcnt_d = 8'd0;
            end
        end
        if (load_wr) begin
            load_d  = PWDATA[CNT_WIDTH-1:0];
            value_d = PWDATA[CNT_WIDTH-1:0];
            pcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
            en_q    <= 1'b0;
            per_q   <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= 8'd0;
            pcnt_q  <= 8'd0;
            load_q  <= '0;
            value_q <= '0;
            tif_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            en_q    <= en_d;
            per_q   <= per_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            load_q  <= load_d;
            value_q <= value_d;
            tif_q   <= tif_d;
            irq_q   <= tif_q & ie_q;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: a zero-wait and a two-wait-state instance on a shared bus,
// directed corner cases plus randomized runs against a closed-form timer model.
module tb_apb_timer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        PSEL0, PSEL2, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA0, PRDATA2;
    logic        PREADY0, PREADY2, PSLVERR0, PSLVERR2, IRQ0, IRQ2;
    logic        sel2;
    logic        m_ready, m_slverr, m_irq;
    logic [31:0] m_rdata;

    always #5 HCLK = ~HCLK;

    apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL0), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA0), .PREADY(PREADY0),
        .PSLVERR(PSLVERR0), .IRQ(IRQ0));

    apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL2), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA2), .PREADY(PREADY2),
        .PSLVERR(PSLVERR2), .IRQ(IRQ2));

    assign m_ready  = sel2 ? PREADY2  : PREADY0;
    assign m_slverr = sel2 ? PSLVERR2 : PSLVERR0;
    assign m_irq    = sel2 ? IRQ2     : IRQ0;
    assign m_rdata  = sel2 ? PRDATA2  : PRDATA0;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] rd;
    logic        err, irqs;
    int          waits, samp;

    task automatic set_psel(input logic v);
        PSEL0 = v & ~sel2;
        PSEL2 = v & sel2;
    endtask

    // Called just after a rising edge; returns just after the edge that completes the transfer.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd);
        set_psel(1'b1);
        PENABLE = 1'b0;
        PADDR   = {28'h0, addr};
        PWRITE  = wr;
        PWDATA  = wd;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge HCLK);
        while (!m_ready && waits < 8) begin
            @(posedge HCLK);
            waits++;
            @(negedge HCLK);
        end
        if (!m_ready) check("ready_timeout", 32'(m_ready), 32'd1);
        rd   = m_rdata;
        err  = m_slverr;
        irqs = m_irq;
        samp = cyc;
        @(posedge HCLK); #1;
        set_psel(1'b0);
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        xfer(1'b1, addr, wd);
    endtask

    task automatic rdr(input logic [3:0] addr);
        xfer(1'b0, addr, 32'h0);
    endtask

    task automatic wait_irq(output int at);
        at = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge HCLK);
            if (IRQ0) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Timer state n clock edges after the enabling write: one tick per PRESC+1 edges,
    // LOAD+1 ticks per timeout.
    function automatic void model(input int ld, input int pr, input logic per, input int n,
                                  output int val, output logic tif, output logic en);
        int k;
        k = (n < 0 ? 0 : n) / (pr + 1);
        if (per) begin
            val = ld - (k % (ld + 1));
            tif = (k >= ld + 1);
            en  = 1'b1;
        end else if (k <= ld) begin
            val = ld - k;
            tif = 1'b0;
            en  = 1'b1;
        end else begin
            val = 0;
            tif = 1'b1;
            en  = 1'b0;
        end
    endfunction

    int          t0, at, ld, pr, v, nw;
    logic        per, ie, t, e, t1, e1;
    logic [7:0]  p8;

    initial begin
        sel2 = 1'b0;
        HRESETn = 1'b0;
        PSEL0 = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;
        #1;
        check("rst_pready0", 32'(PREADY0), 32'd1);
        check("rst_pready2", 32'(PREADY2), 32'd0);
        check("rst_irq", 32'(IRQ0), 32'd0);
        check("rst_pslverr", 32'(PSLVERR0), 32'd0);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int a = 0; a < 16; a += 4) begin
            rdr(4'(a));
            check("rst_read", rd, 32'h0);
            check("rst_read_err", 32'(err), 32'd0);
        end
        wr(4'h4, 32'h1234);
        rdr(4'h4); check("load_rb", rd, 32'h1234);
        rdr(4'h8); check("value_rb", rd, 32'h1234);

        // periodic: LOAD=3, PRESC=1, IE
        wr(4'h4, 32'd3);
        wr(4'h0, 32'h0107);
        t0 = cyc;
        wait_irq(at);
        check("per_irq1_time", 32'(at - t0), 32'd9);
        @(posedge HCLK); #1;
        rdr(4'h8);
        model(3, 1, 1'b1, samp - t0, v, t, e);
        check("per_reload", rd, 32'(v));
        wr(4'hC, 32'h1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("per_irq_clr", 32'(IRQ0), 32'd0);
        wait_irq(at);
        check("per_irq2_time", 32'(at - t0), 32'd17);
        @(posedge HCLK); #1;
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);

        // one-shot: LOAD=2, PRESC=0, IE=0
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h1);
        repeat (6) begin @(posedge HCLK); #1; end
        rdr(4'h0); check("os_ctrl", rd, 32'h0); check("os_irq", 32'(irqs), 32'd0);
        rdr(4'h8); check("os_value", rd, 32'h0);
        rdr(4'hC); check("os_tif", rd, 32'h1);
        wr(4'hC, 32'h1);

        // W1C on the very edge of a one-shot expiry
        wr(4'h4, 32'd1);
        wr(4'h0, 32'h5);
        wr(4'hC, 32'h1);
        rdr(4'hC); check("w1c_race_tif", rd, 32'h1);
        wr(4'hC, 32'h1);
        @(negedge HCLK);
        check("w1c_irq_hold", 32'(IRQ0), 32'd1);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        check("w1c_irq_fall", 32'(IRQ0), 32'd0);
        @(posedge HCLK); #1;
        rdr(4'hC); check("w1c_tif_clr", rd, 32'h0);
        wr(4'h0, 32'h0);

        // error responses
        wr(4'h4, 32'h55);
        wr(4'h8, 32'hFFFF); check("err_wr_value", 32'(err), 32'd1);
        rdr(4'h8); check("err_value_kept", rd, 32'h55); check("ok_rd_err", 32'(err), 32'd0);
        rdr(4'h6); check("err_rd6", 32'(err), 32'd1); check("err_rd6_data", rd, 32'h0);
        wr(4'h1, 32'h1); check("err_wr1", 32'(err), 32'd1);
        rdr(4'h0); check("err_wr1_noeff", rd, 32'h0);

        // wait states and aborted access
        sel2 = 1'b1;
        wr(4'h4, 32'h77); check("ws_waits", 32'(waits), 32'd2); check("ws_err", 32'(err), 32'd0);
        set_psel(1'b1); PENABLE = 1'b0; PADDR = 32'h4; PWRITE = 1'b1; PWDATA = 32'h99;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        check("ws_ready_a1", 32'(PREADY2), 32'd0);
        @(posedge HCLK); #1;
        set_psel(1'b0); PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge HCLK); #1;
        rdr(4'h4); check("abort_load", rd, 32'h77); check("ws_rd_waits", 32'(waits), 32'd2);

        // randomized runs on both instances
        for (int i = 0; i < 24; i++) begin
            sel2 = i[0];
            ld  = int'($urandom_range(0, 6));
            pr  = int'($urandom_range(0, 3));
            per = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            p8  = 8'(pr);
            wr(4'h4, 32'(ld));
            wr(4'h0, {16'h0, p8, 5'h0, ie, per, 1'b1});
            t0 = cyc;
            nw = int'($urandom_range(0, 20));
            repeat (nw) begin @(posedge HCLK); #1; end
            rdr(4'h8);
            model(ld, pr, per, samp - t0, v, t, e);
            check("rnd_value", rd, 32'(v));
            rdr(4'hC);
            model(ld, pr, per, samp - t0, v, t, e);
            model(ld, pr, per, samp - t0 - 1, v, t1, e1);
            check("rnd_tif", rd, 32'(t));
            check("rnd_irq", 32'(irqs), 32'(ie & t1));
            rdr(4'h0);
            model(ld, pr, per, samp - t0, v, t, e);
            check("rnd_ctrl", rd, {16'h0, p8, 5'h0, ie, per, e});
            wr(4'h0, 32'h0);
            wr(4'hC, 32'h1);
        end

        // asynchronous reset in the middle of a count
        sel2 = 1'b0;
        wr(4'h4, 32'd5);
        wr(4'h0, 32'h7);
        repeat (10) begin @(posedge HCLK); #1; end
        check("prerst_irq", 32'(IRQ0), 32'd1);
        PSEL0 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h8;
        HRESETn = 1'b0;
        #1;
        check("midrst_irq", 32'(IRQ0), 32'd0);
        check("midrst_value", PRDATA0, 32'h0);
        PADDR = 32'h0; #1; check("midrst_ctrl", PRDATA0, 32'h0);
        PADDR = 32'h4; #1; check("midrst_load", PRDATA0, 32'h0);
        PADDR = 32'hC; #1; check("midrst_tif", PRDATA0, 32'h0);
        check("midrst_pready", 32'(PREADY0), 32'd1);
        PSEL0 = 1'b0; PENABLE = 1'b0;
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rdr(4'h8); check("postrst_value", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
